// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection with stall hold, deferred redirects and fault halt
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset (0 = in reset)
//   pc_current    address currently held in the PC register
//   stall         hazard freeze request (1 = hold PC)
//   redir_valid   branch/jump redirect this cycle
//   redir_target  redirect destination, qualified by redir_valid
//   pc_next       next-address input of the PC register (combinational)
//   pc_enable     PC register load enable (combinational)
//   halted        1 while in HALT
//   fault_code    00 none, 01 misaligned target, 10 out of window
//   stall_cnt     saturating count of stalled cycles
//   redir_cnt     wrapping count of issued redirects
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_current,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic [31:0] pc_next,
  output logic        pc_enable,
  output logic        halted,
  output logic [1:0]  fault_code,
  output logic [15:0] stall_cnt,
  output logic [7:0]  redir_cnt
);

  localparam logic [31:0] BOOT_ADDR = 32'h0000_3000;
  localparam logic [31:0] WIN_LO    = 32'h0000_3000;
  localparam logic [31:0] WIN_HI    = 32'h0000_6FFC;

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE = 2'b10;

  typedef enum logic [1:0] {RUN, STALL, PEND, HALT} state_t;

  state_t      state;
  logic [31:0] pend_target;

  logic [31:0] candidate;
  logic        cand_counted;
  logic        cand_misaligned;
  logic        cand_out_of_window;
  logic        issue_ok;

  // Candidate priority: live redirect, then the target deferred by a stall,
  // then the sequential address (wraps modulo 2^32).
  always_comb begin
    candidate    = pc_current + 32'd4;
    cand_counted = 1'b0;
    if (redir_valid) begin
      candidate    = redir_target;
      cand_counted = 1'b1;
    end else if (state == PEND) begin
      candidate    = pend_target;
      cand_counted = 1'b1;
    end
  end

  assign cand_misaligned    = (candidate[1:0] != 2'b00);
  assign cand_out_of_window = (candidate < WIN_LO) || (candidate > WIN_HI);
  assign issue_ok           = (state != HALT) && !stall &&
                              !cand_misaligned && !cand_out_of_window;

  // Zero-latency path to the PC register; reset overrides asynchronously.
  always_comb begin
    pc_next   = pc_current;
    pc_enable = 1'b0;
    if (!reset) begin
      pc_next = BOOT_ADDR;
    end else if (issue_ok) begin
      pc_next   = candidate;
      pc_enable = 1'b1;
    end
  end

  assign halted = (state == HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      pend_target <= 32'd0;
      fault_code  <= FAULT_NONE;
      stall_cnt   <= 16'd0;
      redir_cnt   <= 8'd0;
    end else begin
      case (state)
        HALT: begin
          // Terminal: everything frozen until reset.
        end
        default: begin
          if (stall) begin
            if (stall_cnt != 16'hFFFF) begin
              stall_cnt <= stall_cnt + 16'd1;
            end
            // Captured targets are validated only when they issue.
            if (redir_valid) begin
              pend_target <= redir_target;
              state       <= PEND;
            end else if (state != PEND) begin
              state <= STALL;
            end
          end else if (cand_misaligned) begin
            fault_code <= FAULT_ALIGN;
            state      <= HALT;
          end else if (cand_out_of_window) begin
            fault_code <= FAULT_RANGE;
            state      <= HALT;
          end else begin
            // A live redirect releasing PEND replaces the old target,
            // so only one increment happens here.
            if (cand_counted) begin
              redir_cnt <= redir_cnt + 8'd1;
            end
            pend_target <= 32'd0;
            state       <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock.
- reset  in  1  async active-low reset; 0 = in reset.
- pc_current  in  32  address currently held by the PC register.
- stall  in  1  hazard-unit freeze request; 1 = hold PC.
- redir_valid  in  1  branch/jump resolved this cycle; 1 = redirect.
- redir_target  in  32  redirect destination, qualified by redir_valid.
- pc_next  out  32  value driven to the PC register's next-address input.
- pc_enable  out  1  PC register load enable.
- halted  out  1  1 = block is in HALT state.
- fault_code  out  2  00 none, 01 misaligned target, 10 address out of window.
- stall_cnt  out  16  saturating count of stalled cycles.
- redir_cnt  out  8  wrapping count of accepted redirects.
REQ-003 The legal address window SHALL be 0x0000_3000..0x0000_6FFC inclusive, and the boot address SHALL be 0x0000_3000.

Function
REQ-004 The FSM SHALL have states RUN, STALL, PEND and HALT; the state, pending target, fault_code and counters SHALL be registered.
REQ-005 pc_next and pc_enable SHALL be combinational from current state, registers and inputs, with zero-cycle latency to the PC register.
REQ-006 Candidate address selection SHALL use this priority:
- redir_valid=1 selects redir_target;
- otherwise PEND selects pend_target;
- otherwise the candidate is pc_current+4, computed modulo 2^32.
REQ-007 In RUN or PEND with stall=0 and a legal candidate:
- pc_enable=1 and pc_next=candidate;
- next state is RUN;
- redir_cnt increments if the candidate came from redir_valid or pend_target.
REQ-008 With stall=1 in RUN, STALL or PEND:
- pc_enable=0 and pc_next=pc_current;
- stall_cnt increments, saturating at 0xFFFF.
REQ-009 During a stall, redir_valid=1 SHALL capture redir_target into pend_target and move to PEND; a newer redirect overwrites the pending one.
REQ-010 With stall=1 and no pending or incoming redirect, the state SHALL become STALL; STALL with stall=0 SHALL behave as RUN.
REQ-011 When stall falls in PEND and redir_valid=1 in the same cycle, redir_target SHALL win; the older pending target is discarded and counted only once.
REQ-012 A candidate with bits[1:0] != 00, checked at issue time only (stall=0), SHALL trigger a fault:
- pc_enable=0 and pc_next=pc_current;
- fault_code=01 latched;
- next state HALT.
REQ-013 A word-aligned candidate outside the REQ-003 window SHALL trigger a fault:
- pc_enable=0 and fault_code=10 latched, next state HALT;
- this includes pc_current+4 reaching 0x0000_7000 and +4 wrap to 0x0000_0000.
REQ-014 The misalignment check SHALL take precedence over the window check.
REQ-015 HALT SHALL be terminal until reset:
- pc_enable=0, pc_next=pc_current, halted=1;
- counters frozen and all inputs ignored.
REQ-016 A stall-captured target SHALL be checked only when it is issued, not when it is captured.

Reset
REQ-017 While reset=0, outputs SHALL be asynchronously forced to:
- state RUN, pending target cleared, fault_code=00;
- stall_cnt=0, redir_cnt=0, halted=0;
- pc_enable=0 and pc_next=0x0000_3000.
REQ-018 After reset deassertion, the first clock edge SHALL resume normal RUN behaviour.
REQ-019 Reset asserted mid-stall, mid-PEND or in HALT SHALL discard the pending target and the fault with no residual effect.

Verification
REQ-020 Sequential run:
- pc_current=0x3000, no stall or redirect -> pc_next=0x3004, pc_enable=1, redir_cnt=0.
REQ-021 Redirect during stall:
- stall=1 for 3 cycles, redir_valid=1 with 0x3100 in cycle 2 -> pc_enable=0 for 3 cycles and state PEND;
- on release, pc_next=0x3100, pc_enable=1, stall_cnt=3, redir_cnt=1.
REQ-022 Simultaneous release and redirect:
- PEND holds 0x3100; stall falls with redir_valid=1 and 0x3200 -> pc_next=0x3200, redir_cnt increments by 1 only.
REQ-023 Faults:
- redir_target=0x3102 -> fault_code=01, halted=1, pc_enable=0 thereafter;
- pc_current=0x6FFC sequential -> fault_code=10, HALT.
REQ-024 Reset and saturation:
- stall held 70000 cycles -> stall_cnt=0xFFFF;
- reset=0 mid-PEND -> all outputs at REQ-017 values immediately, without a clock edge.
